// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-Lite CSR register bank.
package axi4_lite_pkg;

   localparam int unsigned BYTE_WIDTH = 8;
   localparam int unsigned RESP_WIDTH = 2;

   typedef enum logic [RESP_WIDTH-1:0] {
      RESP_OKAY   = 2'b00,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_t;

   typedef enum logic {
      W_IDLE,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   // Number of byte lanes in a data word.
   function automatic int unsigned lane_count(input int unsigned data_width);
      return data_width / BYTE_WIDTH;
   endfunction

endpackage

// File: rtl/axi4_lite_reg_array.sv
// Register storage with per-byte-lane write enables and read-only gating.
module axi4_lite_reg_array
   import axi4_lite_pkg::*;
#(
   parameter int unsigned          DATA_WIDTH  = 32,
   parameter int unsigned          NUM_REGS    = 16,
   parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [$clog2(NUM_REGS)-1:0]       wr_idx,
   input  logic [DATA_WIDTH-1:0]             wr_data,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  wr_strb,
   input  logic [$clog2(NUM_REGS)-1:0]       rd_idx,
   output logic [DATA_WIDTH-1:0]             rd_data_c
);

   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned STRB_W = DATA_WIDTH / BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Read-only registers silently ignore writes; the response is decided upstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= RESET_VALUE;
         end
      end else if (wr_en) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
               if ((wr_idx == IDX_W'(i)) && !RO_MASK[i] && wr_strb[b]) begin
                  regs[i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
               end
            end
         end
      end
   end

   assign rd_data_c = regs[rd_idx];

endmodule

// File: rtl/axi4_lite_slave_regbank.sv
// AXI4-Lite CSR slave: address decode plus independent write and read channel FSMs.
module axi4_lite_slave_regbank
   import axi4_lite_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           NUM_REGS    = 16,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [ADDR_WIDTH-1:0]             AWADDR,
   input  logic                              AWVALID,
   output logic                              AWREADY,
   input  logic [DATA_WIDTH-1:0]             WDATA,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]  WSTRB,
   input  logic                              WVALID,
   output logic                              WREADY,
   output logic [RESP_WIDTH-1:0]             BRESP,
   output logic                              BVALID,
   input  logic                              BREADY,
   input  logic [ADDR_WIDTH-1:0]             ARADDR,
   input  logic                              ARVALID,
   output logic                              ARREADY,
   output logic [DATA_WIDTH-1:0]             RDATA,
   output logic [RESP_WIDTH-1:0]             RRESP,
   output logic                              RVALID,
   input  logic                              RREADY
);

   localparam int unsigned STRB_W = DATA_WIDTH / BYTE_WIDTH;
   localparam int unsigned ALSB   = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(NUM_REGS);

   function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
      return |(a >> (ALSB + IDX_W));
   endfunction

   wr_state_t               wr_state;
   rd_state_t               rd_state;
   logic                    aw_held, w_held;
   logic [ADDR_WIDTH-1:0]   aw_addr_q;
   logic [DATA_WIDTH-1:0]   w_data_q;
   logic [STRB_W-1:0]       w_strb_q;
   logic                    awready_q, wready_q, bvalid_q;
   resp_t                   bresp_q;
   logic                    arready_q, rvalid_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   resp_t                   rresp_q;

   logic                    aw_hs_c, w_hs_c, ar_hs_c, commit_c;
   logic [ADDR_WIDTH-1:0]   wr_addr_c;
   logic [DATA_WIDTH-1:0]   wr_data_c;
   logic [STRB_W-1:0]       wr_strb_c;
   logic [IDX_W-1:0]        wr_idx_c, rd_idx_c;
   logic                    wr_decerr_c, rd_decerr_c;
   resp_t                   wr_resp_c, rd_resp_c;
   logic [DATA_WIDTH-1:0]   rd_data_c;
   logic                    unused_addr_lsbs;

   assign aw_hs_c = AWVALID && awready_q;
   assign w_hs_c  = WVALID && wready_q;
   assign ar_hs_c = ARVALID && arready_q;

   // A captured beat takes precedence; otherwise use the beat handshaking this edge.
   assign wr_addr_c = aw_held ? aw_addr_q : AWADDR;
   assign wr_data_c = w_held  ? w_data_q  : WDATA;
   assign wr_strb_c = w_held  ? w_strb_q  : WSTRB;
   assign commit_c  = (wr_state == W_IDLE) && (aw_held || aw_hs_c) && (w_held || w_hs_c);

   assign wr_idx_c    = wr_addr_c[ALSB +: IDX_W];
   assign wr_decerr_c = out_of_range(wr_addr_c);
   assign wr_resp_c   = wr_decerr_c        ? RESP_DECERR :
                        RO_MASK[wr_idx_c]  ? RESP_SLVERR : RESP_OKAY;

   assign rd_idx_c    = ARADDR[ALSB +: IDX_W];
   assign rd_decerr_c = out_of_range(ARADDR);
   assign rd_resp_c   = rd_decerr_c ? RESP_DECERR : RESP_OKAY;

   assign unused_addr_lsbs = ^{wr_addr_c[ALSB-1:0], ARADDR[ALSB-1:0]};

   axi4_lite_reg_array #(
      .DATA_WIDTH  (DATA_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .RO_MASK     (RO_MASK),
      .RESET_VALUE (RESET_VALUE)
   ) u_reg_array (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .wr_en     (commit_c && !wr_decerr_c),
      .wr_idx    (wr_idx_c),
      .wr_data   (wr_data_c),
      .wr_strb   (wr_strb_c),
      .rd_idx    (rd_idx_c),
      .rd_data_c (rd_data_c)
   );

   // Write channel: collect AW and W in any order, then hold B until accepted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state  <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (commit_c) begin
                  aw_held   <= 1'b0;
                  w_held    <= 1'b0;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b0;
                  bvalid_q  <= 1'b1;
                  bresp_q   <= wr_resp_c;
                  wr_state  <= W_RESP;
               end else begin
                  if (aw_hs_c) begin
                     aw_held   <= 1'b1;
                     aw_addr_q <= AWADDR;
                  end
                  if (w_hs_c) begin
                     w_held   <= 1'b1;
                     w_data_q <= WDATA;
                     w_strb_q <= WSTRB;
                  end
                  awready_q <= !(aw_held || aw_hs_c);
                  wready_q  <= !(w_held || w_hs_c);
               end
            end
            W_RESP: begin
               if (BREADY) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wr_state  <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // Read channel: one-cycle registered response, held until accepted.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rd_state  <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         case (rd_state)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_hs_c) begin
                  rdata_q   <= rd_decerr_c ? '0 : rd_data_c;
                  rresp_q   <= rd_resp_c;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rd_state  <= R_DATA;
               end
            end
            R_DATA: begin
               if (RREADY) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rd_state  <= R_IDLE;
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi4_lite_slave_regbank.sv
// Directed self-checking bench for the AXI4-Lite register bank (32-bit, 16 regs, reg 1 read-only).
module tb_axi4_lite_slave_regbank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] awaddr, wdata, araddr;
   logic [3:0]  wstrb;
   logic        awvalid, wvalid, bready, arvalid, rready;
   logic        awready, wready, bvalid, arready, rvalid;
   logic [1:0]  bresp, rresp;
   logic [31:0] rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   axi4_lite_slave_regbank #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .NUM_REGS   (16),
      .RO_MASK    (16'h0002),
      .RESET_VALUE(32'h0)
   ) dut (
      .ACLK(clk), .ARESETN(rst_n),
      .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
      .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
      .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
      .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
      .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full write; reports response and whether BVALID was up right after the last handshake.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic b_prompt);
      logic aw_go, w_go;
      int   n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_go = awready; w_go = wready;
         step();
         if (aw_go) awvalid = 1'b0;
         if (w_go)  wvalid  = 1'b0;
         n++;
      end
      if (n >= 20) check("write_addr_data_timeout", 64'(n), 64'(0));
      b_prompt = bvalid;
      n = 0;
      while (!bvalid && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check("write_resp_timeout", 64'(n), 64'(0));
      resp = bresp;
      step();
      bready = 1'b0;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      n = 0;
      while (!arready && n < 20) begin
         step();
         n++;
      end
      step();
      arvalid = 1'b0;
      while (!rvalid && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) check("read_timeout", 64'(n), 64'(0));
      d = rdata; resp = rresp;
      step();
      rready = 1'b0;
   endtask

   logic [1:0]  resp;
   logic        prompt;
   logic [31:0] rd;

   initial begin
      rst_n = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;

      // 1: reset values, READY timing, async reset during a read
      repeat (2) step();
      check("reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'(0));
      rst_n = 1'b1;
      #1;
      check("ready_before_edge", 64'({awready, wready, arready}), 64'(0));
      step();
      check("ready_after_release", 64'({awready, wready, arready}), 64'(3'b111));
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
      step();
      arvalid = 1'b0;
      check("rvalid_before_reset", 64'({rvalid, arready}), 64'(2'b10));
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 64'({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}), 64'(0));
      step();
      rst_n = 1'b1;
      step();
      check("ready_after_second_release", 64'({awready, wready, arready, rvalid}), 64'(4'b1110));

      // 2: basic write/read and overwrite
      axi_write(32'h1C, 32'h0DEADBEE, 4'hF, resp, prompt);
      check("w1c_bresp", 64'(resp), 64'(2'b00));
      check("w1c_b_latency", 64'(prompt), 64'(1));
      axi_read(32'h1C, rd, resp);
      check("r1c_data", 64'(rd), 64'(32'h0DEADBEE));
      check("r1c_rresp", 64'(resp), 64'(2'b00));
      axi_write(32'h1C, 32'h0DEADBE0, 4'hF, resp, prompt);
      axi_read(32'h1C, rd, resp);
      check("r1c_overwrite", 64'(rd), 64'(32'h0DEADBE0));

      // 3: W three cycles ahead of AW, B back-pressured for four cycles
      awaddr = 32'h08; wdata = 32'h12345678; wstrb = 4'hF; bready = 1'b0;
      wvalid = 1'b1;
      step();
      wvalid = 1'b0;
      step();
      step();
      check("w_first_readys", 64'({awready, wready, bvalid}), 64'(3'b100));
      awvalid = 1'b1;
      step();
      awvalid = 1'b0;
      check("late_aw_b", 64'({bvalid, bresp, awready, wready}), 64'(5'b10000));
      for (int i = 0; i < 4; i++) begin
         step();
         check("b_held", 64'({bvalid, bresp, awready, wready}), 64'(5'b10000));
      end
      bready = 1'b1;
      step();
      bready = 1'b0;
      check("b_released", 64'({bvalid, awready, wready}), 64'(3'b011));
      axi_read(32'h08, rd, resp);
      check("r08_data", 64'(rd), 64'(32'h12345678));

      // 4: byte-lane strobes
      axi_write(32'h1C, 32'h0DEADBEE, 4'hF, resp, prompt);
      axi_write(32'h1C, 32'hFFFFFFFF, 4'b0010, resp, prompt);
      check("strb_bresp", 64'(resp), 64'(2'b00));
      axi_read(32'h1C, rd, resp);
      check("strb_lane1", 64'(rd), 64'(32'h0DEAFFEE));
      axi_write(32'h1C, 32'h11111111, 4'b0000, resp, prompt);
      check("strb_zero_bresp", 64'(resp), 64'(2'b00));
      axi_read(32'h1C, rd, resp);
      check("strb_zero_nochange", 64'(rd), 64'(32'h0DEAFFEE));

      // 5: decode error and read-only register
      axi_write(32'h40, 32'hAAAA5555, 4'hF, resp, prompt);
      check("decerr_bresp", 64'(resp), 64'(2'b11));
      axi_read(32'h40, rd, resp);
      check("decerr_rdata", 64'(rd), 64'(0));
      check("decerr_rresp", 64'(resp), 64'(2'b11));
      axi_read(32'h00, rd, resp);
      check("decerr_no_alias_reg0", 64'(rd), 64'(0));
      axi_write(32'h04, 32'h5A5A5A5A, 4'hF, resp, prompt);
      check("ro_bresp", 64'(resp), 64'(2'b10));
      axi_read(32'h04, rd, resp);
      check("ro_unchanged", 64'(rd), 64'(0));
      check("ro_rresp", 64'(resp), 64'(2'b00));

      // 6: read and write to the same register on the same edge
      awaddr = 32'h1C; wdata = 32'hCAFEF00D; wstrb = 4'hF; araddr = 32'h1C;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b0;
      step();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same_edge_rvalid_b", 64'({rvalid, bvalid, bresp}), 64'(4'b1100));
      check("same_edge_old_data", 64'(rdata), 64'(32'h0DEAFFEE));
      for (int i = 0; i < 3; i++) begin
         step();
         check("r_held", 64'({rvalid, rresp, rdata}), {29'h0, 1'b1, 2'b00, 32'h0DEAFFEE});
      end
      bready = 1'b0;
      rready = 1'b1;
      step();
      rready = 1'b0;
      check("r_released", 64'({rvalid, arready}), 64'(2'b01));
      axi_read(32'h1C, rd, resp);
      check("same_edge_new_data", 64'(rd), 64'(32'hCAFEF00D));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
